// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, FSM states,
// datapath mux codes and the packed control-output bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Encoding is visible on the debug state port, so values are pinned.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ADDI  = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decode: state plus latched-opcode flags (and mem_ready in FETCH)
// to the full control bundle. Every field not set for a state stays 0.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   op_illegal,
    input  logic   op_bne,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                // IR and PC advance only in the cycle the fetch actually completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_op     = ALU_ADD;
                ctrl.illegal_op = op_illegal;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
                ctrl.branch_ne     = op_bne;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADDI;
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS main control FSM: state and latched-opcode registers plus
// next-state logic; output decode lives in mips_ctrl_decode.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2,
    parameter bit EN_ADDI  = 1'b1,
    parameter bit EN_JUMP  = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic [3:0]          state
);

    state_t              state_q, state_d, dec_target;
    logic [OPCODE_W-1:0] op_q;
    logic                op_illegal;
    ctrl_t               ctrl;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    // DECODE dispatch uses the live opcode; the register only takes it at the end of DECODE.
    always_comb begin
        dec_target = S_FETCH;
        op_illegal = 1'b0;
        if (opcode == OPCODE_W'(OP_RTYPE))
            dec_target = S_EXEC;
        else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW))
            dec_target = S_MEMADR;
        else if (opcode == OPCODE_W'(OP_BEQ) || opcode == OPCODE_W'(OP_BNE))
            dec_target = S_BRANCH;
        else if (EN_ADDI && opcode == OPCODE_W'(OP_ADDI))
            dec_target = S_IEXEC;
        else if (EN_JUMP && opcode == OPCODE_W'(OP_J))
            dec_target = S_JUMP;
        else
            op_illegal = 1'b1;
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = dec_target;
            S_MEMADR: state_d = (op_q == OPCODE_W'(OP_SW)) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state      (state_q),
        .mem_ready  (mem_ready),
        .op_illegal (op_illegal),
        .op_bne     (op_q == OPCODE_W'(OP_BNE)),
        .ctrl       (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ALUOP_W'(ctrl.alu_op);
    assign pc_source     = ctrl.pc_source;
    assign illegal_op    = ctrl.illegal_op;
    assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multicycle MIPS controller: per-cycle state and
// control-vector checks for each instruction class, wait states and reset abort.
module tb_mips_multicycle_controller;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                           S_RWB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_IEXEC = 4'd11,
                           S_IWB = 4'd12;

    // {pw,pwc,bne,iord}_{mr,mw,irw,m2r}_{rdst,rw,srca}_{srcb}_{aluop}_{pcsrc}_{ill}
    localparam logic [17:0] C_IDLE  = 18'b0000_0000_000_00_00_00_0;
    localparam logic [17:0] C_FETCH = 18'b1000_1010_000_01_00_00_0;
    localparam logic [17:0] C_FWAIT = 18'b0000_1000_000_01_00_00_0;
    localparam logic [17:0] C_DEC   = 18'b0000_0000_000_11_00_00_0;
    localparam logic [17:0] C_DILL  = 18'b0000_0000_000_11_00_00_1;
    localparam logic [17:0] C_EXEC  = 18'b0000_0000_001_00_10_00_0;
    localparam logic [17:0] C_RWB   = 18'b0000_0000_110_00_00_00_0;
    localparam logic [17:0] C_MADR  = 18'b0000_0000_001_10_00_00_0;
    localparam logic [17:0] C_MRD   = 18'b0001_1000_000_00_00_00_0;
    localparam logic [17:0] C_MWB   = 18'b0000_0001_010_00_00_00_0;
    localparam logic [17:0] C_MWR   = 18'b0001_0100_000_00_00_00_0;
    localparam logic [17:0] C_BEQ   = 18'b0100_0000_001_00_01_01_0;
    localparam logic [17:0] C_BNE   = 18'b0110_0000_001_00_01_01_0;
    localparam logic [17:0] C_JMP   = 18'b1000_0000_000_00_00_10_0;
    localparam logic [17:0] C_IEX   = 18'b0000_0000_001_10_11_00_0;
    localparam logic [17:0] C_IWB   = 18'b0000_0000_010_00_00_00_0;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b1;

    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    logic       u2_pc_write, u2_pc_write_cond, u2_branch_ne, u2_i_or_d, u2_mem_read;
    logic       u2_mem_write, u2_ir_write, u2_mem_to_reg, u2_reg_dst, u2_reg_write;
    logic       u2_alu_src_a, u2_illegal_op;
    logic [1:0] u2_alu_src_b, u2_alu_op, u2_pc_source;
    logic [3:0] u2_state;

    logic [17:0] obs;
    assign obs = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                  illegal_op};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mips_multicycle_controller dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    mips_multicycle_controller #(.EN_ADDI(1'b0)) dut_noaddi (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(u2_pc_write), .pc_write_cond(u2_pc_write_cond), .branch_ne(u2_branch_ne),
        .i_or_d(u2_i_or_d), .mem_read(u2_mem_read), .mem_write(u2_mem_write),
        .ir_write(u2_ir_write), .mem_to_reg(u2_mem_to_reg), .reg_dst(u2_reg_dst),
        .reg_write(u2_reg_write), .alu_src_a(u2_alu_src_a), .alu_src_b(u2_alu_src_b),
        .alu_op(u2_alu_op), .pc_source(u2_pc_source), .illegal_op(u2_illegal_op),
        .state(u2_state)
    );

    // Leaves the bench at a falling edge with the DUT freshly out of reset in IDLE.
    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0; opcode = 6'd0; mem_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; opcode = 6'd35; mem_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        n_checks++;
        if (state !== S_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE);
        end
        n_checks++;
        if (obs !== C_IDLE) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", obs, C_IDLE);
        end
        n_checks++;
        if (u2_state !== S_IDLE) begin
            n_fail++; $display("FAIL reset_state_noaddi: got %0d want %0d", u2_state, S_IDLE);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  es [0:5];
        logic [17:0] ec [0:5];
        es = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_RWB, S_FETCH};
        ec = '{C_IDLE, C_FETCH, C_DEC, C_EXEC, C_RWB, C_FETCH};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clock);
            opcode = 6'd0; mem_ready = 1'b1; #1;
            n_checks++;
            if (state !== es[i]) begin
                n_fail++; $display("FAIL rtype_state step %0d: got %0d want %0d", i, state, es[i]);
            end
            n_checks++;
            if (obs !== ec[i]) begin
                n_fail++; $display("FAIL rtype_ctrl step %0d: got %b want %b", i, obs, ec[i]);
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  es [0:9];
        logic [17:0] ec [0:9];
        logic [5:0]  op [0:9];
        logic        mr [0:9];
        es = '{S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD,
               S_MEMWB, S_FETCH};
        ec = '{C_IDLE, C_FETCH, C_DEC, C_MADR, C_MRD, C_MRD, C_MRD, C_MRD, C_MWB, C_FETCH};
        // Opcode flips to SW after DECODE: the latched LW must still steer to MEMRD.
        op = '{6'd35, 6'd35, 6'd35, 6'd43, 6'd43, 6'd43, 6'd43, 6'd43, 6'd43, 6'd43};
        mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clock);
            opcode = op[i]; mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== es[i]) begin
                n_fail++; $display("FAIL lw_state step %0d: got %0d want %0d", i, state, es[i]);
            end
            n_checks++;
            if (obs !== ec[i]) begin
                n_fail++; $display("FAIL lw_ctrl step %0d: got %b want %b", i, obs, ec[i]);
            end
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0]  es [0:7];
        logic [17:0] ec [0:7];
        logic [5:0]  op [0:7];
        logic        mr [0:7];
        es = '{S_IDLE, S_FETCH, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR, S_FETCH};
        ec = '{C_IDLE, C_FWAIT, C_FETCH, C_DEC, C_MADR, C_MWR, C_MWR, C_FETCH};
        op = '{6'd43, 6'd43, 6'd43, 6'd43, 6'd35, 6'd35, 6'd35, 6'd35};
        mr = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            opcode = op[i]; mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== es[i]) begin
                n_fail++; $display("FAIL sw_state step %0d: got %0d want %0d", i, state, es[i]);
            end
            n_checks++;
            if (obs !== ec[i]) begin
                n_fail++; $display("FAIL sw_ctrl step %0d: got %b want %b", i, obs, ec[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0]  es [0:4];
        logic [17:0] ec [0:4];
        logic [5:0]  op [0:4];
        for (int k = 0; k < 2; k++) begin
            es = '{S_IDLE, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
            if (k == 0) begin
                ec = '{C_IDLE, C_FETCH, C_DEC, C_BNE, C_FETCH};
                op = '{6'd5, 6'd5, 6'd5, 6'd4, 6'd4};
            end else begin
                ec = '{C_IDLE, C_FETCH, C_DEC, C_BEQ, C_FETCH};
                op = '{6'd4, 6'd4, 6'd4, 6'd5, 6'd5};
            end
            apply_reset();
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clock);
                opcode = op[i]; mem_ready = 1'b1; #1;
                n_checks++;
                if (state !== es[i]) begin
                    n_fail++;
                    $display("FAIL branch%0d_state step %0d: got %0d want %0d", k, i, state, es[i]);
                end
                n_checks++;
                if (obs !== ec[i]) begin
                    n_fail++;
                    $display("FAIL branch%0d_ctrl step %0d: got %b want %b", k, i, obs, ec[i]);
                end
            end
        end
    endtask

    task automatic test_jump();
        logic [3:0]  es [0:4];
        logic [17:0] ec [0:4];
        es = '{S_IDLE, S_FETCH, S_DECODE, S_JUMP, S_FETCH};
        ec = '{C_IDLE, C_FETCH, C_DEC, C_JMP, C_FETCH};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            opcode = 6'd2; mem_ready = 1'b1; #1;
            n_checks++;
            if (state !== es[i]) begin
                n_fail++; $display("FAIL jump_state step %0d: got %0d want %0d", i, state, es[i]);
            end
            n_checks++;
            if (obs !== ec[i]) begin
                n_fail++; $display("FAIL jump_ctrl step %0d: got %b want %b", i, obs, ec[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  es [0:5];
        logic [17:0] ec [0:5];
        logic [5:0]  op [0:5];
        es = '{S_IDLE, S_FETCH, S_DECODE, S_FETCH, S_DECODE, S_EXEC};
        ec = '{C_IDLE, C_FETCH, C_DILL, C_FETCH, C_DEC, C_EXEC};
        op = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd0, 6'd0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clock);
            opcode = op[i]; mem_ready = 1'b1; #1;
            n_checks++;
            if (state !== es[i]) begin
                n_fail++; $display("FAIL illegal_state step %0d: got %0d want %0d", i, state, es[i]);
            end
            n_checks++;
            if (obs !== ec[i]) begin
                n_fail++; $display("FAIL illegal_ctrl step %0d: got %b want %b", i, obs, ec[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [3:0]  es [0:5];
        logic [17:0] ec [0:5];
        es = '{S_IDLE, S_FETCH, S_DECODE, S_IEXEC, S_IWB, S_FETCH};
        ec = '{C_IDLE, C_FETCH, C_DEC, C_IEX, C_IWB, C_FETCH};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clock);
            opcode = 6'd8; mem_ready = 1'b1; #1;
            n_checks++;
            if (state !== es[i]) begin
                n_fail++; $display("FAIL addi_state step %0d: got %0d want %0d", i, state, es[i]);
            end
            n_checks++;
            if (obs !== ec[i]) begin
                n_fail++; $display("FAIL addi_ctrl step %0d: got %b want %b", i, obs, ec[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (u2_illegal_op !== 1'b1) begin
                    n_fail++; $display("FAIL noaddi_illegal: got %b want 1", u2_illegal_op);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (u2_state !== S_FETCH || u2_illegal_op !== 1'b0 || u2_reg_write !== 1'b0) begin
                    n_fail++;
                    $display("FAIL noaddi_after: state=%0d ill=%b rw=%b want state=%0d ill=0 rw=0",
                             u2_state, u2_illegal_op, u2_reg_write, S_FETCH);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  es [0:8];
        logic [17:0] ec [0:8];
        logic [5:0]  op [0:8];
        es = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_RWB, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        ec = '{C_IDLE, C_FETCH, C_DEC, C_EXEC, C_RWB, C_FETCH, C_DEC, C_BEQ, C_FETCH};
        op = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd4, 6'd4, 6'd4, 6'd4};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clock);
            opcode = op[i]; mem_ready = 1'b1; #1;
            n_checks++;
            if (state !== es[i]) begin
                n_fail++; $display("FAIL b2b_state step %0d: got %0d want %0d", i, state, es[i]);
            end
            n_checks++;
            if (obs !== ec[i]) begin
                n_fail++; $display("FAIL b2b_ctrl step %0d: got %b want %b", i, obs, ec[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] es [0:4];
        logic       mr [0:4];
        es = '{S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
        mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            opcode = 6'd43; mem_ready = mr[i]; #1;
            n_checks++;
            if (state !== es[i]) begin
                n_fail++; $display("FAIL abort_state step %0d: got %0d want %0d", i, state, es[i]);
            end
        end
        n_checks++;
        if (obs !== C_MWR) begin
            n_fail++; $display("FAIL abort_pre_ctrl: got %b want %b", obs, C_MWR);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || state !== S_IDLE) begin
            n_fail++;
            $display("FAIL abort_async: mem_write=%b state=%0d want 0 and %0d", mem_write, state, S_IDLE);
        end
        n_checks++;
        if (obs !== C_IDLE) begin
            n_fail++; $display("FAIL abort_ctrl: got %b want %b", obs, C_IDLE);
        end
        @(negedge clock);
        reset_n = 1'b1; mem_ready = 1'b1; #1;
        n_checks++;
        if (state !== S_IDLE) begin
            n_fail++; $display("FAIL abort_release: got %0d want %0d", state, S_IDLE);
        end
        @(negedge clock); #1;
        n_checks++;
        if (state !== S_FETCH || obs !== C_FETCH) begin
            n_fail++;
            $display("FAIL abort_refetch: state=%0d ctrl=%b want %0d %b", state, obs, S_FETCH, C_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_wait();
        test_branch();
        test_jump();
        test_illegal();
        test_addi();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
